nios_system_pio_edge: RTL and testbench

NIOS_SYSTEM_PIO_EDGE -- requirements
Module: nios_system_pio_edge

---
 rtl/nios_system_pio_edge_if.sv | 19 +
 rtl/nios_system_pio_edge.sv | 141 ++++++++++++++
 tb/tb_nios_system_pio_edge.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_system_pio_edge_if.sv
// Avalon-MM slave bus bundle for the PIO block: word address, select,
// active-low write strobe, 32-bit write/read data.
interface nios_system_pio_edge_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_pio_edge.sv
// Parallel I/O port with output set/clear, synchronised inputs and optional
// edge-capture interrupt logic (enabled by defining PIO_EDGE_IRQ_EN).
module nios_system_pio_edge #(
    parameter int unsigned       WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios_system_pio_edge_if.slave bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic [WIDTH-1:0]      out_port,
    output logic                  irq
);

    typedef enum logic [2:0] {
        ADDR_DATA    = 3'd0,
        ADDR_OUT     = 3'd1,
        ADDR_IRQMASK = 3'd2,
        ADDR_EDGECAP = 3'd3,
        ADDR_OUTSET  = 3'd4,
        ADDR_OUTCLR  = 3'd5
    } reg_addr_e;

    if (WIDTH < 1 || WIDTH > 32 || EDGE_TYPE > 2) begin : g_param_check
        $error("nios_system_pio_edge: WIDTH must be 1..32 and EDGE_TYPE 0..2");
    end

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_irqmask;
    logic [WIDTH-1:0] w_edgecap;
    logic [31:0]      w_rdata;

    assign w_wr    = bus.chipselect & ~bus.write_n;
    assign w_wdata = bus.writedata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_unused
        logic w_unused_wdata;
        assign w_unused_wdata = ^bus.writedata[31:WIDTH];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= RESET_VALUE;
        end else if (w_wr) begin
            case (bus.address)
                ADDR_DATA:   r_out <= w_wdata;
                ADDR_OUTSET: r_out <= r_out | w_wdata;
                ADDR_OUTCLR: r_out <= r_out & ~w_wdata;
                default:     ;
            endcase
        end
    end

    assign out_port = r_out;

`ifdef PIO_EDGE_IRQ_EN
    logic [WIDTH-1:0] r_delay;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [1:0]       r_warm;
    logic             w_cap_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_delay <= '0;
            r_warm  <= '0;
        end else begin
            r_delay <= r_sync2;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
        end
    end

    // Capture is held off until the sync/delay pipeline holds real samples,
    // so an input that is high through reset is not seen as a rising edge.
    assign w_cap_en = (r_warm == 2'd3);

    if (EDGE_TYPE == 0) begin : g_rise
        assign w_edge = r_sync2 & ~r_delay;
    end else if (EDGE_TYPE == 1) begin : g_fall
        assign w_edge = ~r_sync2 & r_delay;
    end else begin : g_any
        assign w_edge = r_sync2 ^ r_delay;
    end

    assign w_clr = (w_wr && bus.address == ADDR_EDGECAP) ? w_wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
            r_edgecap <= '0;
        end else begin
            if (w_wr && bus.address == ADDR_IRQMASK) begin
                r_irqmask <= w_wdata;
            end
            // New edges win over a simultaneous write-1-to-clear.
            r_edgecap <= (r_edgecap & ~w_clr) | (w_cap_en ? w_edge : '0);
        end
    end

    assign w_irqmask = r_irqmask;
    assign w_edgecap = r_edgecap;
    assign irq       = |(r_edgecap & r_irqmask);
`else
    assign w_irqmask = '0;
    assign w_edgecap = '0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_DATA:    w_rdata[WIDTH-1:0] = r_sync2;
            ADDR_OUT:     w_rdata[WIDTH-1:0] = r_out;
            ADDR_IRQMASK: w_rdata[WIDTH-1:0] = w_irqmask;
            ADDR_EDGECAP: w_rdata[WIDTH-1:0] = w_edgecap;
            default:      ;
        endcase
    end

    assign bus.readdata = w_rdata;

endmodule

// File: tb/tb_nios_system_pio_edge.sv
// Self-checking bench for nios_system_pio_edge (WIDTH=8, RESET_VALUE=8'hA5,
// rising-edge capture): vector table, directed corner cases, random vs model.
module tb_nios_system_pio_edge;

    localparam logic [7:0] RV = 8'hA5;
`ifdef PIO_EDGE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] in_port = '0;
    logic [7:0] out_port;
    logic       irq;

    nios_system_pio_edge_if bus_if ();

    nios_system_pio_edge #(
        .WIDTH       (8),
        .RESET_VALUE (RV),
        .EDGE_TYPE   (0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if.slave),
        .in_port  (in_port),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: input history indexed by clock edge since reset release.
    logic [7:0] samp [0:4095];
    int         k = 0;
    logic [7:0] m_out  = RV;
    logic [7:0] m_mask = '0;
    logic [7:0] m_cap  = '0;

    function automatic logic [7:0] past(input int i);
        past = (i < 1) ? 8'h00 : samp[i];
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] a);
        case (a)
            3'd0:    m_rd = {24'h0, past(k - 1)};
            3'd1:    m_rd = {24'h0, m_out};
            3'd2:    m_rd = {24'h0, m_mask};
            3'd3:    m_rd = {24'h0, m_cap};
            default: m_rd = 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic [7:0] wdl;
        logic [7:0] clr;
        logic [7:0] rise;
        wdl = bus_if.writedata[7:0];
        clr = 8'h00;
        k++;
        samp[k] = in_port;
        if (bus_if.chipselect && !bus_if.write_n) begin
            case (bus_if.address)
                3'd0: m_out = wdl;
                3'd4: m_out = m_out | wdl;
                3'd5: m_out = m_out & ~wdl;
                3'd2: if (IRQ_EN) m_mask = wdl;
                3'd3: clr = wdl;
                default: ;
            endcase
        end
        // Value seen by the synchroniser output two edges back vs three edges back.
        rise = (k >= 4) ? (past(k - 2) & ~past(k - 3)) : 8'h00;
        if (IRQ_EN) m_cap = (m_cap & ~clr) | rise;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input logic [7:0] inp);
        @(negedge clk);
        bus_if.address    = a;
        bus_if.chipselect = cs;
        bus_if.write_n    = wn;
        bus_if.writedata  = wd;
        in_port           = inp;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset(input logic [7:0] inp);
        @(negedge clk);
        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = 32'h33;
        in_port           = inp;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_out", {24'h0, out_port}, {24'h0, RV});
        chk("rst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 3'd1;
        #1;
        chk("rst_rd_out", bus_if.readdata, {24'h0, RV});
        bus_if.address = 3'd3;
        #1;
        chk("rst_rd_cap", bus_if.readdata, 32'h0);
        reset_n = 1'b1;
        k      = 0;
        m_out  = RV;
        m_mask = '0;
        m_cap  = '0;
    endtask

    typedef struct {
        logic [2:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [7:0]  inp;
        logic [7:0]  eout;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  ra;
        logic        rcs;
        logic        rwn;
        logic [31:0] rwd;
        logic [7:0]  rin;

        tbl[0]  = '{3'd0, 1'b1, 1'b0, 32'h0000000F, 8'h00, 8'h0F, 32'h0};
        tbl[1]  = '{3'd4, 1'b1, 1'b0, 32'h000000F0, 8'h00, 8'hFF, 32'h0};
        tbl[2]  = '{3'd5, 1'b1, 1'b0, 32'h00000011, 8'h00, 8'hEE, 32'h0};
        tbl[3]  = '{3'd1, 1'b1, 1'b1, 32'h00000000, 8'h00, 8'hEE, 32'hEE};
        tbl[4]  = '{3'd6, 1'b1, 1'b0, 32'hFFFFFFFF, 8'h00, 8'hEE, 32'h0};
        tbl[5]  = '{3'd7, 1'b1, 1'b0, 32'hFFFFFFFF, 8'h00, 8'hEE, 32'h0};
        tbl[6]  = '{3'd1, 1'b1, 1'b0, 32'h00000055, 8'h00, 8'hEE, 32'hEE};
        tbl[7]  = '{3'd0, 1'b0, 1'b0, 32'h00000000, 8'h00, 8'hEE, 32'h0};
        tbl[8]  = '{3'd0, 1'b1, 1'b1, 32'h00000000, 8'h3C, 8'hEE, 32'h0};
        tbl[9]  = '{3'd0, 1'b1, 1'b1, 32'h00000000, 8'h3C, 8'hEE, 32'h3C};
        tbl[10] = '{3'd4, 1'b1, 1'b0, 32'hFFFFFF00, 8'h3C, 8'hEE, 32'h0};
        tbl[11] = '{3'd5, 1'b1, 1'b0, 32'hFFFFFF00, 8'h3C, 8'hEE, 32'h0};

        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'h0;

        do_reset(8'h00);

        for (int unsigned i = 0; i < 12; i++) begin
            step(tbl[i].a, tbl[i].cs, tbl[i].wn, tbl[i].wd, tbl[i].inp);
            chk($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, tbl[i].eout});
            chk($sformatf("vec%0d_rd", i), bus_if.readdata, tbl[i].erd);
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, 32'h0);
        end

`ifdef PIO_EDGE_IRQ_EN
        for (int unsigned i = 0; i < 3; i++) step(3'd0, 1'b1, 1'b1, 32'h0, 8'h00);
        step(3'd3, 1'b1, 1'b0, 32'hFF, 8'h00);
        chk("prep_cap_clear", bus_if.readdata, 32'h0);

        step(3'd2, 1'b1, 1'b0, 32'h01, 8'h00);
        chk("mask_rd", bus_if.readdata, 32'h01);
        step(3'd3, 1'b1, 1'b1, 32'h0, 8'h01);
        chk("rise_n0_cap", bus_if.readdata, 32'h0);
        step(3'd3, 1'b1, 1'b1, 32'h0, 8'h01);
        chk("rise_n1_cap", bus_if.readdata, 32'h0);
        chk("rise_n1_irq", {31'h0, irq}, 32'h0);
        step(3'd3, 1'b1, 1'b1, 32'h0, 8'h01);
        chk("rise_n2_cap", bus_if.readdata, 32'h01);
        chk("rise_n2_irq", {31'h0, irq}, 32'h1);
        step(3'd3, 1'b1, 1'b0, 32'h01, 8'h01);
        chk("w1c_cap", bus_if.readdata, 32'h0);
        chk("w1c_irq", {31'h0, irq}, 32'h0);

        step(3'd3, 1'b1, 1'b1, 32'h0, 8'h05);
        step(3'd3, 1'b1, 1'b1, 32'h0, 8'h05);
        chk("b2_n1_cap", bus_if.readdata, 32'h0);
        step(3'd3, 1'b1, 1'b0, 32'h04, 8'h05);
        chk("set_beats_clr", bus_if.readdata, 32'h04);
        chk("set_beats_clr_irq", {31'h0, irq}, 32'h0);
        step(3'd3, 1'b1, 1'b0, 32'h04, 8'h05);
        chk("b2_cleared", bus_if.readdata, 32'h0);

        for (int unsigned i = 0; i < 4; i++) begin
            step(3'd3, 1'b1, 1'b1, 32'h0, 8'h04);
            chk($sformatf("fall_ignored%0d", i), bus_if.readdata, 32'h0);
        end

        do_reset(8'hFF);
        step(3'd2, 1'b1, 1'b0, 32'hFF, 8'hFF);
        for (int unsigned i = 0; i < 9; i++) begin
            step(3'd3, 1'b1, 1'b1, 32'h0, 8'hFF);
            chk($sformatf("warm_cap%0d", i), bus_if.readdata, 32'h0);
            chk($sformatf("warm_irq%0d", i), {31'h0, irq}, 32'h0);
        end
        step(3'd0, 1'b1, 1'b1, 32'h0, 8'hFF);
        chk("warm_data", bus_if.readdata, 32'hFF);
        chk("warm_out", {24'h0, out_port}, {24'h0, RV});
`else
        step(3'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 8'h00);
        chk("noirq_mask_rd", bus_if.readdata, 32'h0);
        step(3'd3, 1'b1, 1'b0, 32'hFFFFFFFF, 8'h00);
        chk("noirq_cap_rd", bus_if.readdata, 32'h0);
        for (int unsigned i = 0; i < 8; i++) begin
            step(3'd3, 1'b1, 1'b1, 32'h0, (i % 2 == 0) ? 8'hFF : 8'h00);
            chk($sformatf("noirq_irq%0d", i), {31'h0, irq}, 32'h0);
            chk($sformatf("noirq_cap%0d", i), bus_if.readdata, 32'h0);
        end
`endif

        rin = 8'h00;
        for (int unsigned i = 0; i < 400; i++) begin
            ra  = 3'($urandom_range(0, 7));
            rcs = ($urandom_range(0, 3) != 0);
            rwn = ($urandom_range(0, 2) == 0);
            rwd = $urandom;
            if (i % 3 == 0) rin = 8'($urandom);
            step(ra, rcs, rwn, rwd, rin);
            chk("rnd_out", {24'h0, out_port}, {24'h0, m_out});
            chk("rnd_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
            chk("rnd_rd", bus_if.readdata, m_rd(ra));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
